// File: rtl/sevenseg_monitor.sv
// Loopback reader for the hex counter's active-low 7-segment bus: debounces the
// pattern, decodes it to a hex digit and classifies each accepted change.
module sevenseg_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       sevenseg,
    output logic [3:0]       num,
    output logic             valid,
    output logic             invalid,
    output logic             update,
    output logic             step_up,
    output logic             step_down,
    output logic             jump,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       STABLE_LIM = 4'(STABLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [6:0] seg_r;
    logic [6:0] seg_prev;
    logic [6:0] acc_r;
    logic [3:0] stab_cnt;
    logic [3:0] stab_next;
    logic       changed;
    logic       reach_now;
    logic       reached_q;
    logic       accept;
    logic [3:0] dec_val;
    logic       dec_ok;
    logic [3:0] up_val;
    logic [3:0] down_val;
    logic       is_up;
    logic       is_down;

    // A change restarts the count at 1, so with a limit of 1 every change is a fresh reach.
    always_comb begin
        changed   = (seg_r != seg_prev);
        stab_next = '0;
        if (changed)
            stab_next = 4'd1;
        else if (stab_cnt == STABLE_LIM)
            stab_next = STABLE_LIM;
        else
            stab_next = stab_cnt + 4'd1;
        reach_now = (stab_next == STABLE_LIM) && (changed || (stab_cnt != STABLE_LIM));
        // One cycle after the reach, seg_prev still holds the pattern that was stable.
        accept    = reached_q && (seg_prev != acc_r);
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = '0;
        case (seg_prev)
            7'h40: dec_val = 4'h0;
            7'h79: dec_val = 4'h1;
            7'h24: dec_val = 4'h2;
            7'h30: dec_val = 4'h3;
            7'h19: dec_val = 4'h4;
            7'h12: dec_val = 4'h5;
            7'h02: dec_val = 4'h6;
            7'h78: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h10: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        up_val   = num + 4'd1;
        down_val = num - 4'd1;
        is_up    = (dec_val == up_val);
        is_down  = (num != 4'h0) && (dec_val == down_val);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r     <= 7'h7F;
            seg_prev  <= 7'h7F;
            acc_r     <= 7'h7F;
            stab_cnt  <= '0;
            reached_q <= 1'b0;
            num       <= '0;
            valid     <= 1'b0;
            invalid   <= 1'b0;
            update    <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            jump      <= 1'b0;
            err_count <= '0;
        end else begin
            seg_r     <= sevenseg;
            seg_prev  <= seg_r;
            stab_cnt  <= stab_next;
            reached_q <= reach_now;
            update    <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            jump      <= 1'b0;
            if (accept) begin
                acc_r <= seg_prev;
                if (dec_ok) begin
                    num     <= dec_val;
                    valid   <= 1'b1;
                    invalid <= 1'b0;
                    update  <= 1'b1;
                    if (valid) begin
                        step_up   <= is_up;
                        step_down <= !is_up && is_down;
                        jump      <= !is_up && !is_down;
                    end
                end else begin
                    invalid <= 1'b1;
                    if (err_count != '1)
                        err_count <= err_count + ERR_ONE;
                end
            end
        end
    end

endmodule

// File: doc/sevenseg_monitor.md
Name: sevenseg_monitor

Overview:
- Reader for the 7-segment bus driven by the hex counter. It samples the active-low segment pattern and requires the pattern to be stable for a set number of cycles. It then decodes the pattern back to a 4-bit hex value and reports each accepted change as an increment, decrement or jump.
- Sits beside the display driver as an on-chip self-check and loopback source for the counter's sevenseg output. It also counts illegal patterns.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples needed before a pattern is accepted. Legal range 1..15.
- ERR_W, 8: width of the saturating illegal-pattern counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sevenseg  in  7  active-low segments; bit0 = a … bit6 = g. Digit 0 = 7'b1000000.
- num  out  4  last accepted legal hex value.
- valid  out  1  level; num holds a decoded value (high after the first legal accept).
- invalid  out  1  level; the last accepted pattern was illegal.
- update  out  1  one-cycle pulse; a legal pattern was accepted and num was loaded.
- step_up  out  1  one-cycle pulse with update; new = old+1 mod 16.
- step_down  out  1  one-cycle pulse with update; new = old−1, only when old ≠ 0.
- jump  out  1  one-cycle pulse with update; any other legal change while valid was already 1.
- err_count  out  ERR_W  saturating count of accepted illegal patterns.

Behaviour:
- Reset (reset=1 at an edge): all outputs 0.
  - Internal sample reg = 7'h7F, accepted-pattern reg = 7'h7F, stability counter = 0.
  - Reset overrides everything, including an in-progress accept.
- Stage 1: seg_r <= sevenseg every cycle. No other synchroniser; the input comes from the same clock domain.
- Stability counter (4 bits):
  - seg_r ≠ previous seg_r: counter <= 1.
  - Otherwise: counter increments, saturating at STABLE_CYCLES.
- Accept event: the counter reaches STABLE_CYCLES this cycle (not already saturated) and seg_r ≠ accepted-pattern reg.
  - The accepted-pattern reg is then loaded with seg_r.
  - A pattern is accepted at most once per stable period.
- Latency: a new pattern is first present at edge k and held. Outputs and pulses are visible after edge k+STABLE_CYCLES+1.
- Glitch filtering: a pattern held for fewer than STABLE_CYCLES cycles is ignored.
- Returning to the accepted pattern after a glitch produces no event.
- Decode table (pattern → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7.
  - 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - Any other pattern is illegal.
- Legal accept:
  - num <= value; valid <= 1; invalid <= 0; update pulses.
  - Exactly one of step_up, step_down or jump pulses, except on the first legal accept after reset (valid was 0). Then only update pulses.
  - F→0 reports step_up (wrap). 0→F reports jump, never step_down.
- Illegal accept:
  - invalid <= 1; err_count increments, saturating at all-ones.
  - num and valid hold; no update or direction pulse.
- Blank (7'h7F) right after reset equals the accepted-pattern reg, so it is not flagged. A later return to blank is an illegal accept.
- Pulses are exactly one cycle wide. Back-to-back accepts are at least STABLE_CYCLES cycles apart.

Test Plan:
- Reset, then hold 7'h40 for 10 cycles → one update pulse 5 cycles after the change; num=0, valid=1, no step/jump pulse.
- Sequence 40→79→24, each held 8 cycles → num 1 then 2; each step with update+step_up; err_count=0.
- From num=F (0E), apply 40 → step_up; then apply 0E → jump, not step_down; from num=1 (79), apply 40 → step_down.
- Pulse 7'h79 for 3 cycles between holds of 7'h40 → no update; num stays 0.
- Apply 7'h7F for 6 cycles, then 7'h55 → invalid=1, num held, err_count=2; then 300 more illegal accepts → err_count saturates at 255.
- Assert reset mid-hold, 2 cycles after a new pattern starts → all outputs 0 after that edge; pattern still held after release → accepted STABLE_CYCLES+1 edges after release.
